// File: rtl/skinny_sbox_layer_sched.sv
// Byte-serial sequencer for the SKINNY-128 S-box layer on a two-share masked state.
// It feeds one shared masked S-box with a fresh random byte per state byte, from byte 0 to byte 15.
module skinny_sbox_layer_sched #(
  parameter int LAT = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [127:0] in_s0,
  input  logic [127:0] in_s1,
  output logic         busy,
  output logic         done,
  output logic [127:0] out_s0,
  output logic [127:0] out_s1,
  input  logic [7:0]   rnd_data,
  input  logic         rnd_valid,
  output logic         rnd_ready,
  output logic [7:0]   sb_si0,
  output logic [7:0]   sb_si1,
  output logic [7:0]   sb_r,
  input  logic [7:0]   sb_so0,
  input  logic [7:0]   sb_so1
);

  localparam int             HCW       = $clog2(LAT + 1);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(LAT - 1);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;

  state_t         state;
  logic [127:0]   w0, w1;
  logic [127:0]   w0_upd, w1_upd;
  logic [3:0]     idx;
  logic [HCW-1:0] hcnt;
  logic [6:0]     bit_base;

  assign bit_base = {idx, 3'b000};

  // Working state with the current byte replaced by the S-box output shares.
  always_comb begin
    // NOTE: defaults come first so every path assigns both vectors and no latch is inferred.
    w0_upd = w0;
    w1_upd = w1;
    w0_upd[bit_base +: 8] = sb_so0;
    w1_upd[bit_base +: 8] = sb_so1;
  end

  // NOTE: all state, including the 128-bit working registers, is reset, so a layer cut short by reset leaves no trace.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      w0        <= '0;
      w1        <= '0;
      idx       <= '0;
      hcnt      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rnd_ready <= 1'b0;
      sb_si0    <= '0;
      sb_si1    <= '0;
      sb_r      <= '0;
      out_s0    <= '0;
      out_s1    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every read sees the pre-edge value.
      case (state)
        IDLE: begin
          if (start) begin
            w0        <= in_s0;
            w1        <= in_s1;
            idx       <= '0;
            busy      <= 1'b1;
            rnd_ready <= 1'b1;
            state     <= FETCH;
          end
        end
        FETCH: begin
          if (rnd_valid) begin
            sb_si0    <= w0[bit_base +: 8];
            sb_si1    <= w1[bit_base +: 8];
            sb_r      <= rnd_data;
            hcnt      <= '0;
            rnd_ready <= 1'b0;
            state     <= HOLD;
          end
        end
        HOLD: begin
          if (hcnt == HOLD_LAST) begin
            w0 <= w0_upd;
            w1 <= w1_upd;
            if (idx == 4'd15) begin
              // The result is presented in the same cycle that done is high.
              out_s0 <= w0_upd;
              out_s1 <= w1_upd;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              idx       <= idx + 4'd1;
              rnd_ready <= 1'b1;
              state     <= FETCH;
            end
          end else begin
            hcnt <= hcnt + HCW'(1);
          end
        end
        DONE: begin
          done   <= 1'b0;
          busy   <= 1'b0;
          sb_si0 <= '0;
          sb_si1 <= '0;
          sb_r   <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_skinny_sbox_layer_sched.sv
// Self-checking bench for skinny_sbox_layer_sched with a behavioural masked S-box
// that returns garbage unless its inputs have been held for LAT cycles.
module tb_skinny_sbox_layer_sched;

  localparam int LAT     = 4;
  localparam int MAX_CYC = 200;
  localparam int T_DONE  = 16 * (LAT + 1) + 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [127:0] in_s0, in_s1;
  logic         busy, done;
  logic [127:0] out_s0, out_s1;
  logic [7:0]   rnd_data;
  logic         rnd_valid;
  logic         rnd_ready;
  logic [7:0]   sb_si0, sb_si1, sb_r;
  logic [7:0]   sb_so0, sb_so1;

  int n_checks = 0;
  int n_fail   = 0;

  skinny_sbox_layer_sched #(.LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_s0(in_s0), .in_s1(in_s1),
    .busy(busy), .done(done), .out_s0(out_s0), .out_s1(out_s1),
    .rnd_data(rnd_data), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .sb_si0(sb_si0), .sb_si1(sb_si1), .sb_r(sb_r), .sb_so0(sb_so0), .sb_so1(sb_so1)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] s8_mix(input logic [7:0] x);
    return x ^ (~(((x >> 1) | x) >> 2) & 8'h11);
  endfunction

  function automatic logic [7:0] s8_perm(input logic [7:0] x);
    return ((x & 8'h01) << 2) | ((x & 8'h06) << 5) | ((x & 8'h20) >> 5) |
           ((x & 8'hC8) >> 2) | ((x & 8'h10) >> 1);
  endfunction

  // SKINNY 8-bit S-box: three mix/permute rounds, a final mix and a swap of bits 1 and 2.
  function automatic logic [7:0] s8(input logic [7:0] v);
    logic [7:0] x;
    x = v;
    for (int r = 0; r < 3; r++) x = s8_perm(s8_mix(x));
    x = s8_mix(x);
    return (x & 8'hF9) | ((x >> 1) & 8'h02) | ((x << 1) & 8'h04);
  endfunction

  function automatic logic [127:0] layer_ref(input logic [127:0] v);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = s8(v[i*8 +: 8]);
    return r;
  endfunction

  // Masked S-box model: output is wrong until inputs have been stable for LAT cycles.
  int         stable_cnt = 0;
  logic [23:0] sb_prev   = '0;
  always @(negedge clk) begin
    if ({sb_si0, sb_si1, sb_r} !== sb_prev) stable_cnt = 0;
    else if (stable_cnt < 1000) stable_cnt = stable_cnt + 1;
    sb_prev = {sb_si0, sb_si1, sb_r};
  end
  assign sb_so0 = s8(sb_si0 ^ sb_si1) ^ sb_r ^ ((stable_cnt >= LAT - 1) ? 8'h00 : 8'h5A);
  assign sb_so1 = sb_r;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Runs one layer from the current negedge (cycle 0) and records what was observed.
  task automatic run_op(input logic [127:0] a0, input logic [127:0] a1,
                        input int stall_byte, input int stall_len,
                        input int x_cyc_a, input int x_cyc_b,
                        input logic [127:0] x0, input logic [127:0] x1, input int rst_cyc,
                        output int done_cyc, output int n_done, output int n_hs,
                        output int busy_bad, output int sb_bad, output logic [127:0] res);
    logic [23:0] exp_sb;
    int          stall_left;
    logic        hs;
    done_cyc = -1; n_done = 0; n_hs = 0; busy_bad = 0; sb_bad = 0; res = '0;
    exp_sb = '0; stall_left = stall_len;
    start = 1'b1; in_s0 = a0; in_s1 = a1; rnd_valid = 1'b1; rnd_data = 8'($urandom);
    for (int c = 1; c <= MAX_CYC; c++) begin
      @(negedge clk);
      start = (c == x_cyc_a) || (c == x_cyc_b);
      in_s0 = start ? x0 : rand128();
      in_s1 = start ? x1 : rand128();
      if (c == rst_cyc) begin
        rst_n = 1'b0;
        start = 1'b0;
        return;
      end
      if ({sb_si0, sb_si1, sb_r} !== exp_sb) sb_bad++;
      if (done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) begin
          done_cyc = c;
          res = out_s0 ^ out_s1;
        end
      end
      if (busy !== ((done_cyc < 0) || (c == done_cyc))) busy_bad++;
      hs = 1'b0;
      if (rnd_ready === 1'b1 && n_hs == stall_byte && stall_left > 0) begin
        rnd_valid = 1'b0;
        stall_left--;
      end else begin
        rnd_valid = 1'b1;
        hs = (rnd_ready === 1'b1);
      end
      rnd_data = 8'($urandom);
      if (hs) begin
        if (n_hs < 16) exp_sb = {a0[n_hs*8 +: 8], a1[n_hs*8 +: 8], rnd_data};
        n_hs++;
      end
      if (c == done_cyc) exp_sb = '0;
      if (done_cyc >= 0 && c >= done_cyc + 4) break;
    end
    start = 1'b0;
    rnd_valid = 1'b0;
  endtask

  typedef struct {
    string        name;
    logic [127:0] a0, a1;
    int           stall_byte, stall_len;
    int           x_cyc_a, x_cyc_b;
    logic [127:0] x0, x1;
    int           exp_done;
    logic [127:0] exp_res;
  } vec_t;

  task automatic check_run(input string name, input int done_cyc, input int n_done,
                           input int n_hs, input int busy_bad, input int sb_bad,
                           input logic [127:0] res, input int exp_done,
                           input logic [127:0] exp_res);
    check({name, "_done_cycle"}, 128'(done_cyc), 128'(exp_done));
    check({name, "_done_count"}, 128'(n_done), 128'd1);
    check({name, "_handshakes"}, 128'(n_hs), 128'd16);
    check({name, "_busy_window"}, 128'(busy_bad), 128'd0);
    check({name, "_sb_stable"}, 128'(sb_bad), 128'd0);
    check({name, "_result"}, res, exp_res);
    check({name, "_result_held"}, out_s0 ^ out_s1, exp_res);
  endtask

  initial begin
    vec_t         vecs[3];
    int           done_cyc, n_done, n_hs, busy_bad, sb_bad, nz;
    logic [127:0] res, m, a0, a1, un;
    int           sbyte, slen;

    rst_n = 1'b0; start = 1'b0; in_s0 = '0; in_s1 = '0; rnd_data = '0; rnd_valid = 1'b0;

    // Reset values, then a quiet idle period.
    repeat (3) @(negedge clk);
    check("reset_ctrl", {busy, done, rnd_ready, sb_si0, sb_si1, sb_r}, '0);
    check("reset_out_s0", out_s0, '0);
    check("reset_out_s1", out_s1, '0);
    rst_n = 1'b1;
    nz = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      rnd_valid = c[0];
      rnd_data  = 8'($urandom);
      if ({busy, done, rnd_ready, sb_si0, sb_si1, sb_r, out_s0, out_s1} !== '0) nz++;
    end
    check("idle_quiet", 128'(nz), 128'd0);

    m = rand128();
    a0 = rand128();
    a1 = rand128();
    vecs[0] = '{"all_zero", m, m, -1, 0, -1, -1, '0, '0, T_DONE, {16{8'h65}}};
    vecs[1] = '{"stall_b5", a0, a1, 5, 3, -1, -1, '0, '0, T_DONE + 3, layer_ref(a0 ^ a1)};
    vecs[2] = '{"start_busy", a1, a0 ^ 128'h1, -1, 0, 10, T_DONE, rand128(), rand128(),
                T_DONE, layer_ref(a1 ^ a0 ^ 128'h1)};

    foreach (vecs[k]) begin
      run_op(vecs[k].a0, vecs[k].a1, vecs[k].stall_byte, vecs[k].stall_len,
             vecs[k].x_cyc_a, vecs[k].x_cyc_b, vecs[k].x0, vecs[k].x1, -1,
             done_cyc, n_done, n_hs, busy_bad, sb_bad, res);
      check_run(vecs[k].name, done_cyc, n_done, n_hs, busy_bad, sb_bad, res,
                vecs[k].exp_done, vecs[k].exp_res);
    end

    // Exhaustive S-box coverage: layer k carries unmasked bytes 16k+i under random masks.
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < 16; i++) un[i*8 +: 8] = 8'(16 * k + i);
      a1 = rand128();
      a0 = un ^ a1;
      sbyte = $urandom_range(15);
      slen  = $urandom_range(3);
      run_op(a0, a1, sbyte, slen, -1, -1, '0, '0, -1,
             done_cyc, n_done, n_hs, busy_bad, sb_bad, res);
      check_run($sformatf("lut_k%0d", k), done_cyc, n_done, n_hs, busy_bad, sb_bad, res,
                T_DONE + slen, layer_ref(un));
    end

    // Reset during the HOLD window of byte 7 discards the layer.
    a0 = rand128();
    a1 = rand128();
    run_op(a0, a1, -1, 0, -1, -1, '0, '0, 1 + 7 * (LAT + 1) + 2,
           done_cyc, n_done, n_hs, busy_bad, sb_bad, res);
    #1;
    check("midrst_ctrl", {busy, done, rnd_ready, sb_si0, sb_si1, sb_r}, '0);
    check("midrst_out", {out_s0, out_s1} == '0, 128'd1);
    check("midrst_prior_done", 128'(n_done), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    nz = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) nz++;
    end
    check("midrst_no_done", 128'(nz), 128'd0);
    run_op(a0, a1, -1, 0, -1, -1, '0, '0, -1,
           done_cyc, n_done, n_hs, busy_bad, sb_bad, res);
    check_run("after_rst", done_cyc, n_done, n_hs, busy_bad, sb_bad, res,
              T_DONE, layer_ref(a0 ^ a1));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/skinny_sbox_layer_sched.md
# skinny_sbox_layer_sched

Sequencer that applies the SKINNY-128 8-bit S-box layer to a two-share masked 128-bit state. It uses one shared non-pipelined first-order ISW masked S-box instance and processes the 16 bytes one at a time. For each byte it fetches one fresh 8-bit random value, drives the S-box share inputs and randomness, holds them stable for the S-box latency, and captures the output shares. It sits between the round-function datapath and the single `skinny_sbox8_isw1_bypass_non_pipelined` instance.

## Interface

Parameters:
- `LAT`, default 4: S-box latency in clock cycles, i.e. the number of cycles inputs must be held stable before outputs are valid. Legal range is LAT ≥ 1.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: clock; all state is updated on the rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `start` input 1: request to process one layer; sampled only in IDLE.
- `in_s0`, `in_s1` input 128: input shares; byte i is bits [8i+7:8i].
- `busy` output 1: operation in progress.
- `done` output 1: one-cycle pulse when the result is available.
- `out_s0`, `out_s1` output 128: output shares; held until the next done.
- `rnd_data` input 8: fresh randomness.
- `rnd_valid` input 1: `rnd_data` is valid.
- `rnd_ready` output 1: controller accepts randomness this cycle.
- `sb_si0`, `sb_si1` output 8: S-box input shares (registered).
- `sb_r` output 8: S-box randomness (registered).
- `sb_so0`, `sb_so1` input 8: S-box output shares.

## Operation

States:
- **IDLE**
  - `start`=1: latch `in_s0`/`in_s1` into working registers, set byte index i=0, go to FETCH.
  - `start`=0: stay in IDLE.
- **FETCH**
  - `rnd_ready`=1 in this state only.
  - On `rnd_valid`&`rnd_ready`: load `sb_si0`←w0[i], `sb_si1`←w1[i], `sb_r`←`rnd_data`, clear the hold counter, go to HOLD.
  - Otherwise stay in FETCH. `sb_*` keep their previous values; they never change outside this transition, DONE, or reset.
- **HOLD**
  - Count LAT cycles; `sb_*` stay stable throughout.
  - At the last HOLD cycle: w0[i]←`sb_so0`, w1[i]←`sb_so1`.
  - If i=15 go to DONE; else i←i+1 and go to FETCH.
- **DONE**
  - Load `out_s0`/`out_s1` from the working registers.
  - Assert `done` for 1 cycle and clear `sb_si0`/`sb_si1`/`sb_r` to 0.
  - Go to IDLE.

Rules:
- `busy`=1 in FETCH, HOLD and DONE.
- `start` outside IDLE is ignored; it is not queued.
- Byte order is 0 to 15, ascending.
- i is a 4-bit counter and never wraps mid-layer. The hold counter has `$clog2(LAT+1)` bits.
- Each randomness value is used for exactly one byte and is never reused.
- Correctness invariant: `out_s0`^`out_s1` = S8(`in_s0`^`in_s1`) bytewise, where S8 is the SKINNY 8-bit S-box.

## Timing

- **Reset:** asserting `rst_n` (async) forces IDLE and clears all outputs (`busy`, `done`, `rnd_ready`, `sb_*`, `out_s0`, `out_s1`) and the working registers to 0. This holds mid-operation too: no `done` is produced and the partial result is discarded.
- **Per byte:** 1 FETCH cycle (minimum) plus LAT HOLD cycles.
- **Cycle numbering:** `start` is sampled in cycle 0.
  - With `rnd_valid` held at 1, byte i's handshake occurs in cycle 1+i·(LAT+1).
  - `done`=1 in cycle 16·(LAT+1)+1, which is 81 for LAT=4.
  - `busy`=1 in cycles 1..81.
  - IDLE is re-entered in cycle 82; a new `start` is accepted there.
- **Stalls:** each cycle with `rnd_valid`=0 in FETCH adds exactly one cycle of latency.
- **Simultaneous events:** `start` in the same cycle as `done` is ignored, because the controller is not in IDLE.

## Test plan

1. **Reset values:** hold `rst_n`=0 → all outputs are 0 and `rnd_ready`=0. Release and idle 10 cycles → nothing toggles.
2. **All-zero state:** `in_s0`=M, `in_s1`=M (M random), `rnd_valid`=1 constant → `done` in cycle 81, every byte of `out_s0`^`out_s1` = 0x65, `busy` high cycles 1..81, and exactly 16 `rnd_ready` handshakes.
3. **LUT comparison:** unmasked byte i = 16·k+i for k = 0..15 (256 values over 16 layers), random masks, random `sb_r` → each byte matches the `skinny_sbox8_lut` model. `sb_si0`/`sb_si1`/`sb_r` must not change during any HOLD window.
4. **Randomness stall:** deassert `rnd_valid` for 3 cycles while in FETCH for byte 5 → `done` in cycle 84, `sb_*` stable during the stall, result still correct.
5. **Start while busy:** pulse `start` in cycles 10 and 81 with different inputs → one `done` only (cycle 81), and the result reflects the first inputs.
6. **Reset mid-operation:** assert `rst_n`=0 during HOLD of byte 7 → outputs clear immediately and no `done` appears. A fresh `start` then completes in 81 cycles with a correct result.
